// File: rtl/conv_stream_layer.sv
// Streaming K x K x Cin -> Cout convolution with stride, optional same padding, bias and saturation.
// Optional feature macro: CONV_STREAM_LAYER_RELU_EN (negative saturated results output as zero).
module conv_stream_layer #(
  parameter int LineWidthPx = 160,
  parameter int LineCountPx = 120,
  parameter int WidthIn     = 1,
  parameter int WidthOut    = 32,
  parameter int KernelWidth = 3,
  parameter int WeightWidth = 2,
  parameter int InChannels  = 1,
  parameter int OutChannels = 1,
  parameter int Stride      = 1,
  parameter int PadEn       = 0
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_i,
  input  logic                                                  valid_i,
  output logic                                                  ready_o,
  input  logic [InChannels-1:0][WidthIn-1:0]                    data_i,
  output logic                                                  valid_o,
  input  logic                                                  ready_i,
  output logic signed [OutChannels-1:0][WidthOut-1:0]           data_o,
  input  logic signed [OutChannels-1:0][InChannels-1:0][KernelWidth*KernelWidth-1:0][WeightWidth-1:0] weights_i,
  input  logic signed [OutChannels-1:0][WidthOut-1:0]           bias_i
);

  localparam int K    = KernelWidth;
  localparam int P    = (PadEn != 0) ? (K - 1) / 2 : 0;
  localparam int VW   = LineWidthPx + P;
  localparam int VH   = LineCountPx + P;
  localparam int Off  = K - 1 - P;
  localparam int XW   = (VW > 1) ? $clog2(VW) : 1;
  localparam int YW   = (VH > 1) ? $clog2(VH) : 1;
  localparam int AccW = WidthIn + 1 + WeightWidth + $clog2(K * K * InChannels) + 1;
  localparam int SumW = ((AccW > WidthOut) ? AccW : WidthOut) + 1;
  localparam int LbN  = (K > 1) ? K - 1 : 1;

  localparam logic signed [SumW-1:0] SatMax = {{(SumW-WidthOut+1){1'b0}}, {(WidthOut-1){1'b1}}};
  localparam logic signed [SumW-1:0] SatMin = {{(SumW-WidthOut+1){1'b1}}, {(WidthOut-1){1'b0}}};

  typedef enum logic [1:0] {ST_STREAM, ST_PAD_COL, ST_PAD_ROW} state_e;

  state_e                                      state_q, state_d;
  logic [XW-1:0]                               vx_q, vx_d;
  logic [YW-1:0]                               vy_q, vy_d;
  logic [WidthIn-1:0]                          win_q [InChannels][K][K];
  logic [WidthIn-1:0]                          win_d [InChannels][K][K];
  logic [WidthIn-1:0]                          lb_q  [LbN][InChannels][VW];
  logic                                        valid_q;
  logic signed [OutChannels-1:0][WidthOut-1:0] data_q;
  logic signed [OutChannels-1:0][WidthOut-1:0] res;
  logic [InChannels-1:0][WidthIn-1:0]          sample;
  logic                                        out_en, step, produce;
  logic                                        last_col, last_vcol, last_row, last_vrow;
  logic signed [WidthIn:0]                     px;
  logic signed [WeightWidth-1:0]               wv;
  logic signed [SumW-1:0]                      prod, acc;
  int                                          ox_i, oy_i;

  assign out_en  = ~valid_q | ready_i;
  assign ready_o = (state_q == ST_STREAM) & out_en;
  assign step    = (state_q == ST_STREAM) ? (valid_i & ready_o) : out_en;
  assign sample  = (state_q == ST_STREAM) ? data_i : '0;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  assign last_col  = (vx_q == XW'(LineWidthPx - 1));
  assign last_vcol = (vx_q == XW'(VW - 1));
  assign last_row  = (vy_q == YW'(LineCountPx - 1));
  assign last_vrow = (vy_q == YW'(VH - 1));

  always_comb begin
    state_d = state_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    if (step) begin
      case (state_q)
        ST_STREAM: begin
          if (last_col) begin
            if (P > 0) begin
              state_d = ST_PAD_COL;
              vx_d    = vx_q + 1'b1;
            end else begin
              vx_d = '0;
              vy_d = last_row ? '0 : vy_q + 1'b1;
            end
          end else begin
            vx_d = vx_q + 1'b1;
          end
        end
        ST_PAD_COL: begin
          if (last_vcol) begin
            vx_d    = '0;
            vy_d    = vy_q + 1'b1;
            state_d = last_row ? ST_PAD_ROW : ST_STREAM;
          end else begin
            vx_d = vx_q + 1'b1;
          end
        end
        ST_PAD_ROW: begin
          if (last_vcol) begin
            vx_d = '0;
            if (last_vrow) begin
              vy_d    = '0;
              state_d = ST_STREAM;
            end else begin
              vy_d = vy_q + 1'b1;
            end
          end else begin
            vx_d = vx_q + 1'b1;
          end
        end
        default: state_d = ST_STREAM;
      endcase
    end
  end

  // Shift left by one column; the new right column is the current sample over K-1 row delays.
  always_comb begin
    win_d = win_q;
    for (int ci = 0; ci < InChannels; ci++) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[ci][r][c] = win_q[ci][r][c+1];
        end
      end
      win_d[ci][K-1][K-1] = sample[ci];
      for (int j = 0; j < K - 1; j++) begin
        win_d[ci][K-2-j][K-1] = lb_q[j][ci][vx_q];
      end
    end
  end

  // Taps with negative source coordinates are zeroed: this is the left/top padding and also hides stale data.
  always_comb begin
    res  = '0;
    acc  = '0;
    prod = '0;
    px   = '0;
    wv   = '0;
    for (int co = 0; co < OutChannels; co++) begin
      acc = SumW'($signed(bias_i[co]));
      for (int ci = 0; ci < InChannels; ci++) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K; c++) begin
            px = '0;
            if ((int'(vx_q) + c >= K - 1) && (int'(vy_q) + r >= K - 1)) begin
              px = $signed({1'b0, win_d[ci][r][c]});
            end
            wv   = $signed(weights_i[co][ci][r*K+c]);
            prod = SumW'(px) * SumW'(wv);
            acc  = acc + prod;
          end
        end
      end
      if (acc > SatMax) begin
        res[co] = SatMax[WidthOut-1:0];
      end else if (acc < SatMin) begin
        res[co] = SatMin[WidthOut-1:0];
      end else begin
        res[co] = acc[WidthOut-1:0];
      end
`ifdef CONV_STREAM_LAYER_RELU_EN
      if (acc[SumW-1]) begin
        res[co] = '0;
      end
`endif
    end
  end

  always_comb begin
    ox_i    = int'(vx_q) - Off;
    oy_i    = int'(vy_q) - Off;
    produce = step && (ox_i >= 0) && (oy_i >= 0) && ((ox_i % Stride) == 0) && ((oy_i % Stride) == 0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_STREAM;
      vx_q    <= '0;
      vy_q    <= '0;
      win_q   <= '{default: '0};
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      if (step) begin
        win_q <= win_d;
      end
      if (out_en) begin
        valid_q <= produce;
        if (produce) begin
          data_q <= res;
        end
      end
    end
  end

  // Row delay storage needs no reset; its stale contents never reach the sum.
  always_ff @(posedge clk_i) begin
    if (step) begin
      for (int ci = 0; ci < InChannels; ci++) begin
        if (K > 1) begin
          lb_q[0][ci][vx_q] <= sample[ci];
        end
        for (int j = 1; j < K - 1; j++) begin
          lb_q[j][ci][vx_q] <= lb_q[j-1][ci][vx_q];
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_stream_layer.sv
// Bench: a padded/strided instance and a valid-only instance against a direct-convolution reference model.
module tb_conv_stream_layer;
  localparam int W = 6, H = 5, K = 3, WIN = 2, WOUT = 6, WW = 3, CIN = 2, COUT = 2;
  localparam int LIM = 2000;
  localparam int MAXO = 31, MINO = -32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic valid_i [2];
  logic ready_o [2];
  logic valid_o [2];
  logic ready_i [2];
  logic [CIN-1:0][WIN-1:0] data_i [2];
  logic signed [COUT-1:0][WOUT-1:0] data_o [2];
  logic signed [COUT-1:0][CIN-1:0][K*K-1:0][WW-1:0] weights;
  logic signed [COUT-1:0][WOUT-1:0] bias;

  conv_stream_layer #(.LineWidthPx(W), .LineCountPx(H), .WidthIn(WIN), .WidthOut(WOUT), .KernelWidth(K),
                      .WeightWidth(WW), .InChannels(CIN), .OutChannels(COUT), .Stride(2), .PadEn(1)) u_pad (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i[0]), .ready_o(ready_o[0]), .data_i(data_i[0]),
    .valid_o(valid_o[0]), .ready_i(ready_i[0]), .data_o(data_o[0]), .weights_i(weights), .bias_i(bias));

  conv_stream_layer #(.LineWidthPx(W), .LineCountPx(H), .WidthIn(WIN), .WidthOut(WOUT), .KernelWidth(K),
                      .WeightWidth(WW), .InChannels(CIN), .OutChannels(COUT), .Stride(1), .PadEn(0)) u_valid (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i[1]), .ready_o(ready_o[1]), .data_i(data_i[1]),
    .valid_o(valid_o[1]), .ready_i(ready_i[1]), .data_o(data_o[1]), .weights_i(weights), .bias_i(bias));

  int checks = 0;
  int errors = 0;
  int img [H][W][CIN];
  int wt [COUT][CIN][K*K];
  int bs [COUT];
  int exp_q [$];
  int got_q [$];
  int first0, first1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pad_of(input int d);
    return (d == 0) ? (K - 1) / 2 : 0;
  endfunction

  function automatic int str_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (valid_o[d] && ready_i[d]) begin
          for (int c = 0; c < COUT; c++) got_q.push_back(int'($signed(data_o[d][c])));
        end
      end
    end
  end

  // Direct convolution over the real image, zero outside it.
  function automatic void build_exp(input int d);
    int p, s, nx, ny, acc, x, y;
    p  = pad_of(d);
    s  = str_of(d);
    nx = (d == 0) ? W : W - K + 1;
    ny = (d == 0) ? H : H - K + 1;
    for (int oy = 0; oy < ny; oy += s) begin
      for (int ox = 0; ox < nx; ox += s) begin
        for (int co = 0; co < COUT; co++) begin
          acc = bs[co];
          for (int ci = 0; ci < CIN; ci++)
            for (int r = 0; r < K; r++)
              for (int c = 0; c < K; c++) begin
                x = ox - p + c;
                y = oy - p + r;
                if (x >= 0 && x < W && y >= 0 && y < H) acc += img[y][x][ci] * wt[co][ci][r*K+c];
              end
          if (acc > MAXO) acc = MAXO;
          if (acc < MINO) acc = MINO;
`ifdef CONV_STREAM_LAYER_RELU_EN
          if (acc < 0) acc = 0;
`endif
          exp_q.push_back(acc);
        end
      end
    end
  endfunction

  task automatic apply_cfg;
    for (int co = 0; co < COUT; co++) begin
      for (int ci = 0; ci < CIN; ci++)
        for (int t = 0; t < K*K; t++) weights[co][ci][t] = WW'(wt[co][ci][t]);
      bias[co] = WOUT'(bs[co]);
    end
  endtask

  task automatic rand_cfg;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int ci = 0; ci < CIN; ci++) img[y][x][ci] = int'($urandom_range(0, 3));
    for (int co = 0; co < COUT; co++) begin
      for (int ci = 0; ci < CIN; ci++)
        for (int t = 0; t < K*K; t++) wt[co][ci][t] = int'($urandom_range(0, 7)) - 4;
      bs[co] = int'($urandom_range(0, 63)) - 32;
    end
    apply_cfg();
  endtask

  task automatic fill_cfg(input int pix, input int w0, input int w1, input int b0, input int b1);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int ci = 0; ci < CIN; ci++) img[y][x][ci] = pix;
    for (int ci = 0; ci < CIN; ci++)
      for (int t = 0; t < K*K; t++) begin
        wt[0][ci][t] = w0;
        wt[1][ci][t] = w1;
      end
    bs[0] = b0;
    bs[1] = b1;
    apply_cfg();
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_valid_o", int'(valid_o[d]), 0);
      check("rst_data_o", int'(data_o[d]), 0);
      check("rst_ready_o", int'(ready_o[d]), 1);
    end
    @(posedge clk);
    #1;
  endtask

  // mode 0: clean (gap checks), 1: random valid/ready, 2: 10-cycle stall at first result, 3: partial frame
  task automatic run_frame(input int d, input int frames, input int mode, input int npix);
    int waits, w, idx, t, n, p, bad, rdy_seen;
    logic signed [COUT-1:0][WOUT-1:0] hold;
    bit done;
    waits = 0;
    done  = 1'b0;
    p     = pad_of(d);
    fork
      begin
        for (int i = 0; i < npix; i++) begin
          idx = i % (W * H);
          if (mode == 1) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          for (int ci = 0; ci < CIN; ci++) data_i[d][ci] = WIN'(img[idx / W][idx % W][ci]);
          valid_i[d] = 1'b1;
          w = 0;
          @(negedge clk);
          while (!ready_o[d] && w < LIM) begin w++; @(negedge clk); end
          if (w >= LIM) check("accept_timeout", w, 0);
          waits += w;
          @(posedge clk);
          #1 valid_i[d] = 1'b0;
        end
        if (mode == 0) begin
          t = 0;
          @(negedge clk);
          while (!ready_o[d] && t < LIM) begin t++; @(negedge clk); end
          check("pad_tail", t, p + p * (W + p));
          check("row_gaps", waits, frames * (H - 1) * p + (frames - 1) * (p + p * (W + p)));
          @(posedge clk);
          #1;
        end
        done = 1'b1;
      end
      begin
        if (mode == 1) begin
          while (!done) begin
            ready_i[d] = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
          end
          ready_i[d] = 1'b1;
        end else if (mode == 2) begin
          ready_i[d] = 1'b0;
          n = 0;
          while (!valid_o[d] && n < LIM) begin @(posedge clk); #1; n++; end
          if (n >= LIM) check("first_valid_timeout", n, 0);
          hold = data_o[d];
          bad = 0;
          rdy_seen = 0;
          repeat (10) begin
            @(negedge clk);
            if (data_o[d] !== hold) bad++;
            if (ready_o[d]) rdy_seen++;
          end
          @(posedge clk);
          #1 ready_i[d] = 1'b1;
          check("stall_data_changes", bad, 0);
          check("stall_ready_high", rdy_seen, 0);
        end
      end
    join
  endtask

  task automatic finish_frame(input int d, input int frames);
    int n;
    exp_q.delete();
    for (int f = 0; f < frames; f++) build_exp(d);
    n = 0;
    while (got_q.size() < exp_q.size() && n < LIM) begin @(posedge clk); n++; end
    repeat (20) @(posedge clk);
    #1;
    check($sformatf("out_count_d%0d", d), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("out_d%0d[%0d]", d, i), got_q[i], exp_q[i]);
    first0 = (got_q.size() > 0) ? got_q[0] : -999;
    first1 = (got_q.size() > 1) ? got_q[1] : -999;
    got_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      valid_i[d] = 1'b0;
      ready_i[d] = 1'b1;
      data_i[d]  = '0;
    end
    rand_cfg();
    do_reset();

    run_frame(0, 1, 0, W * H);
    finish_frame(0, 1);
    run_frame(1, 2, 0, 2 * W * H);
    finish_frame(1, 2);

    fill_cfg(1, 1, 0, 0, 5);
    run_frame(0, 1, 0, W * H);
    finish_frame(0, 1);
    check("ones_pad_corner", first0, 4 * CIN);
    check("ch1_bias_pad", first1, 5);
    run_frame(1, 1, 0, W * H);
    finish_frame(1, 1);
    check("ones_valid_first", first0, 9 * CIN);
    check("ch1_bias_valid", first1, 5);

    fill_cfg(3, 3, 3, 0, 0);
    run_frame(0, 1, 0, W * H);
    finish_frame(0, 1);
    check("sat_high", first0, MAXO);
    fill_cfg(3, -4, -4, 0, 0);
    run_frame(1, 1, 0, W * H);
    finish_frame(1, 1);
`ifdef CONV_STREAM_LAYER_RELU_EN
    check("sat_low_relu", first0, 0);
`else
    check("sat_low", first0, MINO);
`endif

    rand_cfg();
    run_frame(0, 1, 2, W * H);
    finish_frame(0, 1);

    repeat (3) begin
      rand_cfg();
      run_frame(0, 1, 1, W * H);
      finish_frame(0, 1);
      rand_cfg();
      run_frame(1, 1, 1, W * H);
      finish_frame(1, 1);
    end

    rand_cfg();
    run_frame(0, 1, 3, 15);
    do_reset();
    got_q.delete();
    run_frame(0, 1, 0, W * H);
    finish_frame(0, 1);
    run_frame(1, 1, 3, 7);
    do_reset();
    got_q.delete();
    run_frame(1, 1, 0, W * H);
    finish_frame(1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
